ahb_dw64to32_bridge: RTL and testbench

AHB-Lite data-width bridge sitting directly downstream of the two-master instruction/load-store mux. It accepts the mux's single 64-bit AHB-Lite master stream and replays each transfer on a 32-bit AHB-Lite bus toward memories and peripherals. Doubleword (HSIZE=3) accesses become two back-to-back pipelined 32-bit NONSEQ transfers. The upstream data phase is stalled until the last downstream beat completes.

---
 rtl/ahb_pkg.sv | 29 ++
 rtl/ahb_dw64to32_bridge.sv | 117 +++++++++++
 tb/tb_ahb_dw64to32_bridge.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite transfer constants and bridge state encoding
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam int ST_IDLE_BIT = 0;
    localparam int ST_A0_BIT   = 1;
    localparam int ST_D0_BIT   = 2;
    localparam int ST_D1_BIT   = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001 << ST_IDLE_BIT,
        ST_A0   = 4'b0001 << ST_A0_BIT,
        ST_D0   = 4'b0001 << ST_D0_BIT,
        ST_D1   = 4'b0001 << ST_D1_BIT
    } state_t;

    // Sizes above a doubleword cannot be carried by a 64-bit master; fold them to doubleword.
    function automatic logic [2:0] clamp_size(input logic [2:0] hsize);
        return (hsize >= HSIZE_DWORD) ? HSIZE_DWORD : hsize;
    endfunction

endpackage

// File: rtl/ahb_dw64to32_bridge.sv
// rtl/ahb_dw64to32_bridge.sv - 64-bit to 32-bit AHB-Lite bridge, doublewords split into two beats
module ahb_dw64to32_bridge
    import ahb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic [AW-1:0] HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [63:0]   HWDATA,
    output logic          HREADY,
    output logic [63:0]   HRDATA,
    output logic [AW-1:0] M_HADDR,
    output logic [1:0]    M_HTRANS,
    output logic          M_HWRITE,
    output logic [2:0]    M_HSIZE,
    output logic [31:0]   M_HWDATA,
    input  logic [31:0]   M_HRDATA,
    input  logic          M_HREADY
);

    state_t        state;
    logic          addr2_q;
    logic [2:0]    size_q;
    logic [31:0]   wdata_hi_q;
    logic [31:0]   rdata_lo_q;

    logic [2:0]    size_in;
    logic [AW-1:0] addr_in;
    logic          is_dword;
    logic          last_beat;
    logic          accept;
    logic          unused_htrans0;

    assign unused_htrans0 = HTRANS[0];

    assign size_in   = clamp_size(HSIZE);
    assign addr_in   = (size_in == HSIZE_DWORD) ? {HADDR[AW-1:3], 3'b000} : HADDR;
    assign is_dword  = (size_q == HSIZE_DWORD);
    assign last_beat = (state == ST_D1) || ((state == ST_D0) && !is_dword);

    assign HREADY = (state == ST_IDLE) || (last_beat && M_HREADY);
    assign accept = HTRANS[1] && HREADY;

    // Narrow reads are replicated on both halves; the upstream side picks its lane by addr[2].
    assign HRDATA = (last_beat && M_HREADY)
                  ? (is_dword ? {M_HRDATA, rdata_lo_q} : {M_HRDATA, M_HRDATA})
                  : 64'd0;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            addr2_q    <= 1'b0;
            size_q     <= HSIZE_BYTE;
            wdata_hi_q <= 32'd0;
            rdata_lo_q <= 32'd0;
            M_HADDR    <= '0;
            M_HTRANS   <= HTRANS_IDLE;
            M_HWRITE   <= 1'b0;
            M_HSIZE    <= HSIZE_BYTE;
            M_HWDATA   <= 32'd0;
        end else if (accept) begin
            state    <= ST_A0;
            addr2_q  <= HADDR[2];
            size_q   <= size_in;
            M_HADDR  <= addr_in;
            M_HTRANS <= HTRANS_NONSEQ;
            M_HWRITE <= HWRITE;
            M_HSIZE  <= (size_in == HSIZE_DWORD) ? HSIZE_WORD : size_in;
        end else begin
            case (state)
                ST_IDLE: begin
                    M_HTRANS <= HTRANS_IDLE;
                end
                ST_A0: begin
                    wdata_hi_q <= HWDATA[63:32];
                    if (M_HREADY) begin
                        state    <= ST_D0;
                        M_HWDATA <= (is_dword || !addr2_q) ? HWDATA[31:0] : HWDATA[63:32];
                        if (is_dword) begin
                            // Second beat's address phase overlaps the first beat's data phase.
                            M_HADDR <= {M_HADDR[AW-1:3], 3'b100};
                        end else begin
                            M_HTRANS <= HTRANS_IDLE;
                        end
                    end
                end
                ST_D0: begin
                    if (M_HREADY) begin
                        M_HTRANS <= HTRANS_IDLE;
                        if (is_dword) begin
                            state      <= ST_D1;
                            rdata_lo_q <= M_HRDATA;
                            M_HWDATA   <= wdata_hi_q;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_D1: begin
                    if (M_HREADY) begin
                        state    <= ST_IDLE;
                        M_HTRANS <= HTRANS_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    M_HTRANS <= HTRANS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_dw64to32_bridge.sv
// tb/tb_ahb_dw64to32_bridge.sv - self-checking bench for ahb_dw64to32_bridge
module tb_ahb_dw64to32_bridge;

    localparam int AW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [63:0]   HWDATA;
    logic          HREADY;
    logic [63:0]   HRDATA;
    logic [AW-1:0] M_HADDR;
    logic [1:0]    M_HTRANS;
    logic          M_HWRITE;
    logic [2:0]    M_HSIZE;
    logic [31:0]   M_HWDATA;
    logic [31:0]   M_HRDATA;
    logic          M_HREADY;

    logic          use_model;
    logic          s_hready, d_hready;
    logic [31:0]   s_hrdata, d_hrdata;

    assign M_HREADY = use_model ? s_hready : d_hready;
    assign M_HRDATA = use_model ? s_hrdata : d_hrdata;

    int checks = 0;
    int errors = 0;

    always #5 HCLK = ~HCLK;

    ahb_dw64to32_bridge #(.AW(AW)) dut (
        .HCLK     (HCLK),
        .HRESET   (HRESET),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .M_HADDR  (M_HADDR),
        .M_HTRANS (M_HTRANS),
        .M_HWRITE (M_HWRITE),
        .M_HSIZE  (M_HSIZE),
        .M_HWDATA (M_HWDATA),
        .M_HRDATA (M_HRDATA),
        .M_HREADY (M_HREADY)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [63:0] wdata;
        logic [31:0] rd0, rd1;
        logic [31:0] a0;
        logic [2:0]  s0;
        logic [31:0] a1, d0, d1;
        logic [63:0] hrdata;
    } vec_t;

    vec_t vecs[8];

    // Zero-wait single transfer; called at posedge+1 with the bridge idle.
    task automatic run_vec(input int i, input vec_t v);
        bit dw = (v.size >= 3);
        HADDR = v.addr; HTRANS = 2'b10; HWRITE = v.write; HSIZE = v.size;
        HWDATA = {$urandom, $urandom}; d_hready = 1'b1; d_hrdata = $urandom;
        @(negedge HCLK);
        chk($sformatf("v%0d_t0_hready", i), HREADY, 1);
        cyc();
        HTRANS = 2'b00; HADDR = $urandom; HWDATA = v.wdata;
        @(negedge HCLK);
        chk($sformatf("v%0d_a0_htrans", i), M_HTRANS, 2'b10);
        chk($sformatf("v%0d_a0_haddr", i), M_HADDR, v.a0);
        chk($sformatf("v%0d_a0_hsize", i), M_HSIZE, v.s0);
        chk($sformatf("v%0d_a0_hwrite", i), M_HWRITE, v.write);
        chk($sformatf("v%0d_t1_hready", i), HREADY, 0);
        chk($sformatf("v%0d_t1_hrdata", i), HRDATA, 0);
        cyc();
        d_hrdata = v.rd0; HWDATA = {$urandom, $urandom};
        @(negedge HCLK);
        chk($sformatf("v%0d_d0_hwdata", i), M_HWDATA, v.d0);
        if (dw) begin
            chk($sformatf("v%0d_a1_htrans", i), M_HTRANS, 2'b10);
            chk($sformatf("v%0d_a1_haddr", i), M_HADDR, v.a1);
            chk($sformatf("v%0d_a1_hsize", i), M_HSIZE, 2);
            chk($sformatf("v%0d_t2_hready", i), HREADY, 0);
            cyc();
            d_hrdata = v.rd1;
            @(negedge HCLK);
            chk($sformatf("v%0d_d1_htrans", i), M_HTRANS, 2'b00);
            chk($sformatf("v%0d_d1_hwdata", i), M_HWDATA, v.d1);
        end
        chk($sformatf("v%0d_done_hready", i), HREADY, 1);
        chk($sformatf("v%0d_done_hrdata", i), HRDATA, v.hrdata);
        cyc();
    endtask

    // ---------------- randomized traffic against a byte-level reference ----------------
    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [63:0] wdata;
    } xfer_t;

    logic [7:0]  ref_mem[256];
    logic [31:0] slv_mem[64];

    function automatic logic [7:0] init_byte(input int a);
        return 8'(a) ^ 8'h5A;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        int b = a & 'hFC;
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic [63:0] ref_read(input xfer_t x);
        int a = int'(x.addr[7:0]);
        if (x.size >= 3)
            return {ref_word((a & 'hF8) + 4), ref_word(a & 'hF8)};
        return {ref_word(a), ref_word(a)};
    endfunction

    task automatic ref_write(input xfer_t x);
        int n = (x.size >= 3) ? 8 : (1 << x.size);
        int start = int'(x.addr[7:0]) & ~(n - 1);
        for (int k = 0; k < n; k++)
            ref_mem[start+k] = x.wdata[8*((start+k)%8) +: 8];
    endtask

    task automatic slv_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n = 1 << ((s > 2) ? 2 : int'(s));
        int start = int'(a[7:0]) & ~(n - 1);
        for (int k = 0; k < n; k++) begin
            int b = start + k;
            slv_mem[b>>2][8*(b%4) +: 8] = d[8*(b%4) +: 8];
        end
    endtask

    function automatic xfer_t gen();
        xfer_t x;
        x.size  = 3'($urandom_range(0, 7));
        x.write = 1'($urandom_range(0, 1));
        x.addr  = 32'($urandom_range(0, 255));
        if (x.size < 3) x.addr = x.addr & ~((32'd1 << x.size) - 1);
        x.wdata = {$urandom, $urandom};
        return x;
    endfunction

    task automatic run_random(input int n_xfers);
        xfer_t       cur, nxt;
        bit          cur_v = 0, nxt_v = 0, p_v = 0;
        int          issued = 0, done = 0, k = 0, zeros = 0, ncyc = 0;
        logic [31:0] p_addr = 0;
        logic        p_write = 0;
        logic [2:0]  p_size = 0;
        logic        prev_mready = 1;
        logic [1:0]  prev_trans = 0;
        logic [31:0] prev_addr = 0, prev_wdata = 0;
        logic [2:0]  prev_size = 0;
        for (int a = 0; a < 256; a++) ref_mem[a] = init_byte(a);
        for (int w = 0; w < 64; w++)
            slv_mem[w] = {init_byte(4*w+3), init_byte(4*w+2), init_byte(4*w+1), init_byte(4*w)};
        use_model = 1'b1; s_hready = 1'b1; s_hrdata = $urandom; HTRANS = 2'b00;
        while (done < n_xfers && ncyc < 20000) begin
            @(negedge HCLK);
            ncyc++;
            chk("m_htrans_legal", (M_HTRANS == 2'b00) || (M_HTRANS == 2'b10), 1);
            if (M_HTRANS[1]) chk("m_hsize_max", M_HSIZE <= 3'd2, 1);
            if (!prev_mready && prev_trans[1]) begin
                chk("stall_haddr", M_HADDR, prev_addr);
                chk("stall_htrans", M_HTRANS, prev_trans);
                chk("stall_hsize", M_HSIZE, prev_size);
            end
            if (!prev_mready && p_v && p_write) chk("stall_hwdata", M_HWDATA, prev_wdata);
            if (!HREADY) chk("hrdata_zero_when_busy", HRDATA, 0);
            if (!cur_v) begin
                chk("hready_when_idle", HREADY, 1);
                chk("hrdata_zero_when_idle", HRDATA, 0);
            end
            // downstream slave: retire the data phase, then take a new address phase
            if (p_v && M_HREADY) begin
                if (p_write) slv_write(p_addr, p_size, M_HWDATA);
                p_v = 0;
            end
            if (M_HTRANS[1] && M_HREADY) begin
                p_addr = M_HADDR; p_write = M_HWRITE; p_size = M_HSIZE; p_v = 1;
            end
            prev_mready = M_HREADY; prev_trans = M_HTRANS; prev_addr = M_HADDR;
            prev_size = M_HSIZE; prev_wdata = M_HWDATA;
            // upstream master
            if (cur_v) begin
                k++;
                if (HREADY) begin
                    chk("latency", k, ((cur.size >= 3) ? 3 : 2) + zeros);
                    if (cur.write) ref_write(cur);
                    else chk("rd_data", HRDATA, ref_read(cur));
                    done++;
                end else if (!M_HREADY) begin
                    zeros++;
                end
            end
            if (HREADY) begin
                if (nxt_v) begin
                    cur = nxt; cur_v = 1; nxt_v = 0; k = 0; zeros = 0;
                end else begin
                    cur_v = 0;
                end
            end
            if (!nxt_v && issued < n_xfers && $urandom_range(0, 2) != 0) begin
                nxt = gen(); nxt_v = 1; issued++;
            end
            cyc();
            s_hready = ($urandom_range(0, 3) != 0);
            s_hrdata = (p_v && !p_write) ? slv_mem[p_addr[7:2]] : $urandom;
            if (nxt_v) begin
                HTRANS = 2'b10; HADDR = nxt.addr; HWRITE = nxt.write; HSIZE = nxt.size;
            end else begin
                HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom); HSIZE = 3'($urandom);
            end
            HWDATA = cur_v ? cur.wdata : {$urandom, $urandom};
        end
        chk("random_all_done", done, n_xfers);
        for (int w = 0; w < 64; w++)
            chk($sformatf("mem_word_%0d", w), slv_mem[w], ref_word(4*w));
        HTRANS = 2'b00;
        @(negedge HCLK);
        cyc();
        use_model = 1'b0;
    endtask

    initial begin
        logic [31:0] b0, b1;
        HRESET = 1'b1; HTRANS = 2'b00; HADDR = 0; HWRITE = 0; HSIZE = 0; HWDATA = 0;
        use_model = 1'b0; d_hready = 1'b1; d_hrdata = 0; s_hready = 1'b1; s_hrdata = 0;

        vecs[0] = '{32'h0000_0104, 1'b0, 3'd2, 64'hCAFEF00D_12345678, 32'hDEADBEEF, 32'h0,
                    32'h0000_0104, 3'd2, 32'h0, 32'hCAFEF00D, 32'h0, 64'hDEADBEEF_DEADBEEF};
        vecs[1] = '{32'h0000_0208, 1'b1, 3'd3, 64'h11223344_55667788, 32'hA5A5A5A5, 32'h5A5A5A5A,
                    32'h0000_0208, 3'd2, 32'h0000_020C, 32'h55667788, 32'h11223344, 64'h5A5A5A5A_A5A5A5A5};
        vecs[2] = '{32'h0000_0007, 1'b1, 3'd0, 64'hAABBCCDD_01020304, 32'h13572468, 32'h0,
                    32'h0000_0007, 3'd0, 32'h0, 32'hAABBCCDD, 32'h0, 64'h13572468_13572468};
        vecs[3] = '{32'h0000_0013, 1'b0, 3'd3, 64'h0F0F0F0F_F0F0F0F0, 32'h01234567, 32'h89ABCDEF,
                    32'h0000_0010, 3'd2, 32'h0000_0014, 32'hF0F0F0F0, 32'h0F0F0F0F, 64'h89ABCDEF_01234567};
        vecs[4] = '{32'h0000_002A, 1'b1, 3'd1, 64'h99887766_55443322, 32'h0BADF00D, 32'h0,
                    32'h0000_002A, 3'd1, 32'h0, 32'h55443322, 32'h0, 64'h0BADF00D_0BADF00D};
        vecs[5] = '{32'h0000_0100, 1'b0, 3'd5, 64'hFEDCBA98_76543210, 32'h11111111, 32'h22222222,
                    32'h0000_0100, 3'd2, 32'h0000_0104, 32'h76543210, 32'hFEDCBA98, 64'h22222222_11111111};
        vecs[6] = '{32'hFFFF_FFFC, 1'b1, 3'd2, 64'h12345678_9ABCDEF0, 32'h0, 32'h0,
                    32'hFFFF_FFFC, 3'd2, 32'h0, 32'h12345678, 32'h0, 64'h0};
        vecs[7] = '{32'h8000_0006, 1'b0, 3'd7, 64'h0000000A_0000000B, 32'h33, 32'h44,
                    32'h8000_0000, 3'd2, 32'h8000_0004, 32'h0000000B, 32'h0000000A, 64'h00000044_00000033};

        repeat (3) @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rst_hready", HREADY, 1);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_m_haddr", M_HADDR, 0);
        chk("rst_m_htrans", M_HTRANS, 0);
        chk("rst_m_hwrite", M_HWRITE, 0);
        chk("rst_m_hsize", M_HSIZE, 0);
        chk("rst_m_hwdata", M_HWDATA, 0);
        cyc();

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // doubleword read at 0x10 with two downstream wait cycles in D0
        b0 = 32'hC0DE0001; b1 = 32'hC0DE0002;
        HADDR = 32'h10; HTRANS = 2'b10; HWRITE = 0; HSIZE = 3'd3; d_hready = 1;
        cyc();
        HTRANS = 2'b00;
        @(negedge HCLK);
        chk("stl_a0_haddr", M_HADDR, 32'h10);
        for (int s = 0; s < 2; s++) begin
            cyc();
            d_hready = 0; d_hrdata = $urandom;
            @(negedge HCLK);
            chk($sformatf("stl_hold_haddr%0d", s), M_HADDR, 32'h14);
            chk($sformatf("stl_hold_htrans%0d", s), M_HTRANS, 2'b10);
            chk($sformatf("stl_hold_hready%0d", s), HREADY, 0);
        end
        cyc();
        d_hready = 1; d_hrdata = b0;
        @(negedge HCLK);
        chk("stl_d0_hready", HREADY, 0);
        chk("stl_d0_haddr", M_HADDR, 32'h14);
        cyc();
        d_hrdata = b1;
        @(negedge HCLK);
        chk("stl_done_hready", HREADY, 1);
        chk("stl_done_hrdata", HRDATA, {b1, b0});
        cyc();

        // back-to-back word reads: second address on the first's completing cycle
        HADDR = 32'h40; HTRANS = 2'b10; HWRITE = 0; HSIZE = 3'd2;
        cyc();
        HTRANS = 2'b00;
        @(negedge HCLK);
        chk("b2b_t1_hready", HREADY, 0);
        cyc();
        HADDR = 32'h84; HTRANS = 2'b10; d_hrdata = 32'h600DF00D;
        @(negedge HCLK);
        chk("b2b_first_hready", HREADY, 1);
        chk("b2b_first_hrdata", HRDATA, 64'h600DF00D_600DF00D);
        cyc();
        HTRANS = 2'b00;
        @(negedge HCLK);
        chk("b2b_a0_htrans", M_HTRANS, 2'b10);
        chk("b2b_a0_haddr", M_HADDR, 32'h84);
        chk("b2b_a0_hready", HREADY, 0);
        cyc();
        d_hrdata = 32'h7EA7BEEF;
        @(negedge HCLK);
        chk("b2b_second_hready", HREADY, 1);
        chk("b2b_second_hrdata", HRDATA, 64'h7EA7BEEF_7EA7BEEF);
        cyc();

        // reset asserted in D0 of a doubleword read
        HADDR = 32'h30; HTRANS = 2'b10; HWRITE = 0; HSIZE = 3'd3;
        cyc();
        HTRANS = 2'b00;
        cyc();
        HRESET = 1'b1; d_hrdata = 32'h12121212;
        @(negedge HCLK);
        chk("rstd0_pre_haddr", M_HADDR, 32'h34);
        cyc();
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rstd0_hready", HREADY, 1);
        chk("rstd0_htrans", M_HTRANS, 0);
        chk("rstd0_haddr", M_HADDR, 0);
        chk("rstd0_hrdata", HRDATA, 0);
        for (int s = 0; s < 2; s++) begin
            cyc();
            @(negedge HCLK);
            chk($sformatf("rstd0_no_beat%0d", s), M_HTRANS, 0);
        end
        cyc();

        run_random(400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
